// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce bank: width helper, hold-FSM encodings and default timing.
package debounce_pkg;

   localparam int DEFAULT_SETTLE_10MS = 1_000_000;

   typedef enum logic [1:0] {
      STATE_IDLE      = 2'd0,
      STATE_WAIT_HOLD = 2'd1,
      STATE_REPEAT    = 2'd2
   } hold_state_t;

   // Bits needed to hold values 0 .. value-1.
   function automatic int clog2(input longint value);
      int result;
      result = 0;
      while ((longint'(1) << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/debounce_chan.sv
// One conditioned input: 2-FF synchroniser, settle filter, press/release strobes, hold/repeat FSM.
module debounce_chan
   import debounce_pkg::*;
#(
   parameter int SETTLE_CYCLES = DEFAULT_SETTLE_10MS,
   parameter int ACTIVE_LOW    = 1,
   parameter int HOLD_CYCLES   = 100_000_000,
   parameter int REPEAT_CYCLES = 25_000_000
) (
   input  logic clk_100_MHz,
   input  logic rst,
   input  logic btn_in,
   output logic level,
   output logic press,
   output logic released,
   output logic hold
);

   localparam logic IDLE_PIN = (ACTIVE_LOW != 0);
   localparam int   SCNT_W   = clog2(longint'(SETTLE_CYCLES) + 1);
   localparam int   HMAX_RAW = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int   HMAX     = (HMAX_RAW < 1) ? 1 : HMAX_RAW;
   localparam int   HCNT_W   = clog2(longint'(HMAX) + 1);

   logic              s1;
   logic              s2;
   logic              sample;
   logic [SCNT_W-1:0] scnt;
   logic              accept;

   hold_state_t       state;
   hold_state_t       state_nx;
   logic [HCNT_W-1:0] hcnt;
   logic [HCNT_W-1:0] hcnt_nx;
   logic              hold_nx;

   assign sample = s2 ^ IDLE_PIN;
   // High on the edge where the sample has disagreed with level for SETTLE_CYCLES cycles.
   assign accept = (sample != level) && (scnt == SCNT_W'(SETTLE_CYCLES - 1));

   // NOTE: sync FFs reset to the inactive pin value so a released pin never looks like an edge.
   always_ff @(posedge clk_100_MHz or posedge rst) begin
      if (rst) begin
         s1       <= IDLE_PIN;
         s2       <= IDLE_PIN;
         scnt     <= '0;
         level    <= 1'b0;
         press    <= 1'b0;
         released <= 1'b0;
      end else begin
         s1       <= btn_in;
         s2       <= s1;
         press    <= accept &  sample;
         released <= accept & ~sample;
         if (sample == level) begin
            scnt <= '0;
         end else if (accept) begin
            level <= sample;
            scnt  <= '0;
         end else begin
            scnt <= scnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_100_MHz or posedge rst) begin
      if (rst) begin
         state <= STATE_IDLE;
         hcnt  <= '0;
         hold  <= 1'b0;
      end else begin
         state <= state_nx;
         hcnt  <= hcnt_nx;
         hold  <= hold_nx;
      end
   end

   // NOTE: every output of this block is defaulted first so no path can infer a latch.
   always_comb begin
      state_nx = state;
      hcnt_nx  = hcnt;
      hold_nx  = 1'b0;
      if (accept && !sample) begin
         // A release in the same cycle as a hold threshold suppresses the strobe.
         state_nx = STATE_IDLE;
         hcnt_nx  = '0;
      end else begin
         case (state)
            STATE_IDLE: begin
               if (accept && sample && (HOLD_CYCLES > 0)) begin
                  state_nx = STATE_WAIT_HOLD;
                  hcnt_nx  = '0;
               end
            end
            STATE_WAIT_HOLD: begin
               if (hcnt == HCNT_W'(HOLD_CYCLES - 1)) begin
                  hold_nx  = 1'b1;
                  hcnt_nx  = '0;
                  state_nx = STATE_REPEAT;
               end else begin
                  hcnt_nx = hcnt + 1'b1;
               end
            end
            STATE_REPEAT: begin
               // With REPEAT_CYCLES == 0 the channel parks here silently until release.
               if (REPEAT_CYCLES > 0) begin
                  if (hcnt == HCNT_W'(REPEAT_CYCLES - 1)) begin
                     hold_nx = 1'b1;
                     hcnt_nx = '0;
                  end else begin
                     hcnt_nx = hcnt + 1'b1;
                  end
               end
            end
            default: begin
               state_nx = STATE_IDLE;
               hcnt_nx  = '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/debounce_bank.sv
// N-channel switch conditioner; the release strobe port is named 'released' because 'release' is a reserved word.
module debounce_bank
   import debounce_pkg::*;
#(
   parameter int CHANNELS      = 4,
   parameter int SETTLE_CYCLES = DEFAULT_SETTLE_10MS,
   parameter int ACTIVE_LOW    = 1,
   parameter int HOLD_CYCLES   = 100_000_000,
   parameter int REPEAT_CYCLES = 25_000_000
) (
   input  logic                clk_100_MHz,
   input  logic                rst,
   input  logic [CHANNELS-1:0] btn_in,
   output logic [CHANNELS-1:0] level,
   output logic [CHANNELS-1:0] press,
   output logic [CHANNELS-1:0] released,
   output logic [CHANNELS-1:0] hold
);

   for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
      debounce_chan #(
         .SETTLE_CYCLES (SETTLE_CYCLES),
         .ACTIVE_LOW    (ACTIVE_LOW),
         .HOLD_CYCLES   (HOLD_CYCLES),
         .REPEAT_CYCLES (REPEAT_CYCLES)
      ) u_chan (
         .clk_100_MHz (clk_100_MHz),
         .rst         (rst),
         .btn_in      (btn_in[ch]),
         .level       (level[ch]),
         .press       (press[ch]),
         .released    (released[ch]),
         .hold        (hold[ch])
      );
   end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: reset, bounce, glitch, hold/repeat, independence, reset mid-operation.
module tb_debounce_bank;

   localparam int CHANNELS = 4;
   localparam int SETTLE   = 8;
   localparam int HOLD     = 32;
   localparam int REPEAT   = 16;

   logic                clk_100_MHz;
   logic                rst;
   logic [CHANNELS-1:0] btn_in;
   logic [CHANNELS-1:0] level;
   logic [CHANNELS-1:0] press;
   logic [CHANNELS-1:0] released;
   logic [CHANNELS-1:0] hold;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int p        = 0;

   int                  press_n   [CHANNELS];
   int                  release_n [CHANNELS];
   int                  hold_n    [CHANNELS];
   int                  hold_cyc  [CHANNELS][8];
   logic [CHANNELS-1:0] strobe_seen;
   logic [CHANNELS-1:0] level_seen;

   debounce_bank #(
      .CHANNELS      (CHANNELS),
      .SETTLE_CYCLES (SETTLE),
      .ACTIVE_LOW    (1),
      .HOLD_CYCLES   (HOLD),
      .REPEAT_CYCLES (REPEAT)
   ) dut (
      .clk_100_MHz (clk_100_MHz),
      .rst         (rst),
      .btn_in      (btn_in),
      .level       (level),
      .press       (press),
      .released    (released),
      .hold        (hold)
   );

   initial clk_100_MHz = 1'b0;
   always #5 clk_100_MHz = ~clk_100_MHz;

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   task automatic clear_log();
      for (int c = 0; c < CHANNELS; c++) begin
         press_n[c]   = 0;
         release_n[c] = 0;
         hold_n[c]    = 0;
         for (int k = 0; k < 8; k++) hold_cyc[c][k] = 0;
      end
      strobe_seen = '0;
      level_seen  = '0;
   endtask

   // Advance one clock, then sample outputs 1 ns after the edge and log strobes.
   task automatic tick();
      @(posedge clk_100_MHz);
      #1;
      cyc++;
      for (int c = 0; c < CHANNELS; c++) begin
         if (press[c]) press_n[c]++;
         if (released[c]) release_n[c]++;
         if (hold[c]) begin
            if (hold_n[c] < 8) hold_cyc[c][hold_n[c]] = cyc;
            hold_n[c]++;
         end
      end
      strobe_seen = strobe_seen | press | released | hold;
      level_seen  = level_seen | level;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst    = 1'b1;
      btn_in = 4'b0000;
      clear_log();

      // 1: reset with all pins pressed, then pins held through deassert
      run(3);
      check("rst_level", level, 4'h0);
      check("rst_press", press, 4'h0);
      check("rst_release", released, 4'h0);
      check("rst_hold", hold, 4'h0);
      clear_log();
      rst = 1'b0;
      run(9);
      check("t1_no_early_strobe", strobe_seen, 4'h0);
      check("t1_level_before", level, 4'h0);
      run(1);
      check("t1_press_at_10", press, 4'hF);
      check("t1_level_at_10", level, 4'hF);
      btn_in = 4'hF;
      run(10);
      check("t1_release_all", released, 4'hF);
      check("t1_level_cleared", level, 4'h0);
      check("t1_press_count", press_n[0] + press_n[1] + press_n[2] + press_n[3], 4);
      check("t1_no_hold", hold_n[0] + hold_n[1] + hold_n[2] + hold_n[3], 0);
      run(5);
      clear_log();

      // 2: bounce on ch0 -- low 5, high 2, then low steady
      btn_in[0] = 1'b0;
      run(5);
      btn_in[0] = 1'b1;
      run(2);
      btn_in[0] = 1'b0;
      run(9);
      check("t2_no_early_press", strobe_seen, 4'h0);
      check("t2_level_before", level, 4'h0);
      run(1);
      check("t2_press", press, 4'h1);
      check("t2_level", level, 4'h1);
      run(5);
      check("t2_single_press", press_n[0], 1);
      btn_in[0] = 1'b1;
      run(10);
      check("t2_release", released, 4'h1);
      check("t2_level_off", level, 4'h0);
      run(5);
      clear_log();

      // 3: ch1 low for 7 cycles only -- one short of the settle time
      btn_in[1] = 1'b0;
      run(7);
      btn_in[1] = 1'b1;
      run(20);
      check("t3_level_never", level_seen, 4'h0);
      check("t3_no_strobe", strobe_seen, 4'h0);
      clear_log();

      // 4: ch2 held ~100 cycles after press, then released
      btn_in[2] = 1'b0;
      run(10);
      check("t4_press", press, 4'h4);
      p = cyc;
      run(99);
      btn_in[2] = 1'b1;
      run(10);
      check("t4_release", released, 4'h4);
      run(30);
      check("t4_hold_count", hold_n[2], 5);
      for (int i = 0; i < 5; i++) check($sformatf("t4_hold_%0d", i), hold_cyc[2][i] - p, 32 + 16 * i);
      check("t4_release_count", release_n[2], 1);
      check("t4_other_holds", hold_n[0] + hold_n[1] + hold_n[3], 0);
      clear_log();

      // 5: ch0 and ch3 together, ch3 released mid-hold
      btn_in[0] = 1'b0;
      btn_in[3] = 1'b0;
      run(10);
      check("t5_press_pair", press, 4'h9);
      p = cyc;
      run(19);
      btn_in[3] = 1'b1;
      run(10);
      check("t5_release_ch3", released, 4'h8);
      check("t5_level_ch0_only", level, 4'h1);
      run(21);
      check("t5_ch0_hold_count", hold_n[0], 2);
      check("t5_ch0_hold_0", hold_cyc[0][0] - p, 32);
      check("t5_ch0_hold_1", hold_cyc[0][1] - p, 48);
      check("t5_ch3_no_hold", hold_n[3], 0);
      btn_in[0] = 1'b1;
      run(10);
      check("t5_release_ch0", released, 4'h1);
      run(20);
      check("t5_ch0_no_late_hold", hold_n[0], 2);
      clear_log();

      // 6: reset while ch2 repeats and ch1 settle count is at 5
      btn_in[2] = 1'b0;
      run(10);
      check("t6_press", press, 4'h4);
      run(40);
      btn_in[1] = 1'b0;
      run(7);
      rst = 1'b1;
      #1;
      check("t6_level_reset", level, 4'h0);
      check("t6_strobes_reset", press | released | hold, 4'h0);
      clear_log();
      run(5);
      check("t6_quiet_in_reset", strobe_seen | level_seen, 4'h0);
      btn_in = 4'hF;
      run(1);
      rst = 1'b0;
      run(30);
      check("t6_no_strobe_after", strobe_seen, 4'h0);
      check("t6_level_after", level_seen, 4'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
